// File: rtl/sdio_multi.sv
// sdio_multi: multi-channel control fan-out, DMA round-robin arbiter and
// interrupt aggregator for NCH SDIO/eMMC controller channels.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_wb_*  / o_wb_*          control slave (one outstanding request)
//   o_ch_wb_* / i_ch_wb_*     per-channel control masters (cyc/stb one-hot,
//                             we/addr/data/sel shared by all channels)
//   i_ch_dma_* / o_ch_dma_*   per-channel DMA slaves (read data broadcast)
//   o_dma_* / i_dma_*         shared memory master, owned by one channel
//   i_ch_int                  raw channel interrupts
//   o_int_vec, o_int          registered interrupt vector and its OR
module sdio_multi #(
    parameter  int NCH   = 2,
    parameter  int AW    = 45,
    parameter  int DW    = 64,
    localparam int LGNCH = $clog2(NCH),
    localparam int MW    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    // control slave
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    input  logic                   i_wb_we,
    input  logic [LGNCH+2:0]       i_wb_addr,
    input  logic [MW-1:0]          i_wb_data,
    input  logic [MW/8-1:0]        i_wb_sel,
    output logic                   o_wb_stall,
    output logic                   o_wb_ack,
    output logic [MW-1:0]          o_wb_data,
    // per-channel control masters
    output logic [NCH-1:0]         o_ch_wb_cyc,
    output logic [NCH-1:0]         o_ch_wb_stb,
    output logic                   o_ch_wb_we,
    output logic [2:0]             o_ch_wb_addr,
    output logic [MW-1:0]          o_ch_wb_data,
    output logic [MW/8-1:0]        o_ch_wb_sel,
    input  logic [NCH-1:0]         i_ch_wb_stall,
    input  logic [NCH-1:0]         i_ch_wb_ack,
    input  logic [NCH*MW-1:0]      i_ch_wb_data,
    // per-channel DMA slaves
    input  logic [NCH-1:0]         i_ch_dma_cyc,
    input  logic [NCH-1:0]         i_ch_dma_stb,
    input  logic [NCH-1:0]         i_ch_dma_we,
    input  logic [NCH*AW-1:0]      i_ch_dma_addr,
    input  logic [NCH*DW-1:0]      i_ch_dma_data,
    input  logic [NCH*DW/8-1:0]    i_ch_dma_sel,
    output logic [NCH-1:0]         o_ch_dma_stall,
    output logic [NCH-1:0]         o_ch_dma_ack,
    output logic [NCH-1:0]         o_ch_dma_err,
    output logic [DW-1:0]          o_ch_dma_data,
    // shared memory master
    output logic                   o_dma_cyc,
    output logic                   o_dma_stb,
    output logic                   o_dma_we,
    output logic [AW-1:0]          o_dma_addr,
    output logic [DW-1:0]          o_dma_data,
    output logic [DW/8-1:0]        o_dma_sel,
    input  logic                   i_dma_stall,
    input  logic                   i_dma_ack,
    input  logic                   i_dma_err,
    input  logic [DW-1:0]          i_dma_data,
    // interrupts
    input  logic [NCH-1:0]         i_ch_int,
    output logic                   o_int,
    output logic [NCH-1:0]         o_int_vec
);

    localparam logic [LGNCH:0] NCH_W = (LGNCH+1)'(NCH);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // ------------------------------------------------------------------
    // Control path
    // ------------------------------------------------------------------
    state_t             state, state_nxt;
    logic [LGNCH-1:0]   ch_q;
    logic               we_q;
    logic [2:0]         addr_q;
    logic [MW-1:0]      data_q;
    logic [MW/8-1:0]    sel_q;
    logic               stb_pend, stb_pend_nxt;
    logic               ack_nxt;
    logic [MW-1:0]      rdata_nxt;
    logic               accept;
    logic [LGNCH-1:0]   req_ch;
    logic               req_in_range;
    logic [NCH-1:0]     ch_onehot;
    logic               ch_stall, ch_ack;
    logic [MW-1:0]      ch_rdata;

    always_comb begin
        req_ch       = i_wb_addr[LGNCH+2:3];
        // Only reachable when NCH is not a power of two.
        req_in_range = ({1'b0, req_ch} < NCH_W);

        ch_onehot = '0;
        ch_stall  = 1'b0;
        ch_ack    = 1'b0;
        ch_rdata  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(ch_q) == k) begin
                ch_onehot[k] = 1'b1;
                ch_stall     = i_ch_wb_stall[k];
                ch_ack       = i_ch_wb_ack[k];
                ch_rdata     = i_ch_wb_data[k*MW +: MW];
            end
        end

        state_nxt    = state;
        stb_pend_nxt = stb_pend;
        ack_nxt      = 1'b0;
        rdata_nxt    = '0;
        accept       = 1'b0;
        o_wb_stall   = 1'b0;
        o_ch_wb_cyc  = '0;
        o_ch_wb_stb  = '0;

        case (state)
            S_IDLE: begin
                accept = i_wb_cyc & i_wb_stb;
                if (accept) begin
                    if (req_in_range) begin
                        state_nxt    = S_BUSY;
                        stb_pend_nxt = 1'b1;
                    end else begin
                        // Nonexistent channel: answer locally with zero data.
                        ack_nxt = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                o_wb_stall = 1'b1;
                if (!i_wb_cyc) begin
                    // Abort: drop the channel bus immediately, no ack.
                    state_nxt    = S_IDLE;
                    stb_pend_nxt = 1'b0;
                end else begin
                    o_ch_wb_cyc = ch_onehot;
                    if (stb_pend) begin
                        o_ch_wb_stb = ch_onehot;
                        if (!ch_stall) begin
                            stb_pend_nxt = 1'b0;
                        end
                    end
                    if (ch_ack) begin
                        ack_nxt      = 1'b1;
                        rdata_nxt    = ch_rdata;
                        stb_pend_nxt = 1'b0;
                        state_nxt    = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            stb_pend  <= 1'b0;
            ch_q      <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            state     <= state_nxt;
            stb_pend  <= stb_pend_nxt;
            o_wb_ack  <= ack_nxt;
            o_wb_data <= rdata_nxt;
            if (accept) begin
                ch_q <= req_ch;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            we_q   <= i_wb_we;
            addr_q <= i_wb_addr[2:0];
            data_q <= i_wb_data;
            sel_q  <= i_wb_sel;
        end
    end

    assign o_ch_wb_we   = we_q;
    assign o_ch_wb_addr = addr_q;
    assign o_ch_wb_data = data_q;
    assign o_ch_wb_sel  = sel_q;

    // ------------------------------------------------------------------
    // DMA arbiter
    // ------------------------------------------------------------------
    logic               gnt_valid;
    logic [LGNCH-1:0]   gnt, last;
    logic               err_lock;
    logic               gnt_cyc, gnt_stb, gnt_we;
    logic [AW-1:0]      gnt_addr;
    logic [DW-1:0]      gnt_data;
    logic [DW/8-1:0]    gnt_sel;
    logic               found;
    logic [LGNCH-1:0]   pick;
    logic               gnt_release;

    always_comb begin
        gnt_cyc  = 1'b0;
        gnt_stb  = 1'b0;
        gnt_we   = 1'b0;
        gnt_addr = '0;
        gnt_data = '0;
        gnt_sel  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(gnt) == k) begin
                gnt_cyc  = i_ch_dma_cyc[k];
                gnt_stb  = i_ch_dma_stb[k];
                gnt_we   = i_ch_dma_we[k];
                gnt_addr = i_ch_dma_addr[k*AW +: AW];
                gnt_data = i_ch_dma_data[k*DW +: DW];
                gnt_sel  = i_ch_dma_sel[k*(DW/8) +: DW/8];
            end
        end

        // Round-robin: channels above the last owner first, then wrap.
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && i_ch_dma_cyc[k] && (k > int'(last))) begin
                found = 1'b1;
                pick  = LGNCH'(k);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (!found && i_ch_dma_cyc[k] && (k <= int'(last))) begin
                found = 1'b1;
                pick  = LGNCH'(k);
            end
        end

        o_ch_dma_stall = '1;
        o_ch_dma_ack   = '0;
        o_ch_dma_err   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_valid && (int'(gnt) == k)) begin
                o_ch_dma_stall[k] = i_dma_stall | err_lock;
                o_ch_dma_ack[k]   = i_dma_ack;
                o_ch_dma_err[k]   = i_dma_err;
            end
        end
    end

    assign gnt_release = gnt_valid & ~gnt_cyc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            gnt_valid <= 1'b0;
            gnt       <= '0;
            last      <= LGNCH'(NCH-1);
            err_lock  <= 1'b0;
        end else begin
            if (gnt_valid && !gnt_release && i_dma_err) begin
                err_lock <= 1'b1;
            end
            if (gnt_release) begin
                gnt_valid <= 1'b0;
                err_lock  <= 1'b0;
            end
            // Re-arbitrating on the release edge keeps the owner change to a
            // single idle cycle; the releasing channel has cyc low and is
            // searched last, so it cannot win again here.
            if ((!gnt_valid || gnt_release) && found) begin
                gnt_valid <= 1'b1;
                gnt       <= pick;
                last      <= pick;
            end
        end
    end

    assign o_dma_cyc     = gnt_valid & gnt_cyc & ~err_lock;
    assign o_dma_stb     = gnt_valid & gnt_stb & ~err_lock;
    assign o_dma_we      = gnt_we;
    assign o_dma_addr    = gnt_addr;
    assign o_dma_data    = gnt_data;
    assign o_dma_sel     = gnt_sel;
    assign o_ch_dma_data = i_dma_data;

    // ------------------------------------------------------------------
    // Interrupts
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_int_vec <= '0;
        end else begin
            o_int_vec <= i_ch_int;
        end
    end

    assign o_int = |o_int_vec;

endmodule

// File: tb/tb_sdio_multi.sv
// Self-checking bench for sdio_multi (NCH=3): directed control/DMA scenarios
// plus randomized DMA and interrupt traffic against a behavioural model.
module tb_sdio_multi;

    localparam int NCH   = 3;
    localparam int LGNCH = 2;
    localparam int MW    = 32;
    localparam int AW    = 45;
    localparam int DW    = 64;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic                 i_wb_cyc, i_wb_stb, i_wb_we;
    logic [LGNCH+2:0]     i_wb_addr;
    logic [MW-1:0]        i_wb_data;
    logic [MW/8-1:0]      i_wb_sel;
    logic                 o_wb_stall, o_wb_ack;
    logic [MW-1:0]        o_wb_data;
    logic [NCH-1:0]       o_ch_wb_cyc, o_ch_wb_stb;
    logic                 o_ch_wb_we;
    logic [2:0]           o_ch_wb_addr;
    logic [MW-1:0]        o_ch_wb_data;
    logic [MW/8-1:0]      o_ch_wb_sel;
    logic [NCH-1:0]       i_ch_wb_stall, i_ch_wb_ack;
    logic [NCH*MW-1:0]    i_ch_wb_data;
    logic [NCH-1:0]       i_ch_dma_cyc, i_ch_dma_stb, i_ch_dma_we;
    logic [NCH*AW-1:0]    i_ch_dma_addr;
    logic [NCH*DW-1:0]    i_ch_dma_data;
    logic [NCH*DW/8-1:0]  i_ch_dma_sel;
    logic [NCH-1:0]       o_ch_dma_stall, o_ch_dma_ack, o_ch_dma_err;
    logic [DW-1:0]        o_ch_dma_data;
    logic                 o_dma_cyc, o_dma_stb, o_dma_we;
    logic [AW-1:0]        o_dma_addr;
    logic [DW-1:0]        o_dma_data;
    logic [DW/8-1:0]      o_dma_sel;
    logic                 i_dma_stall, i_dma_ack, i_dma_err;
    logic [DW-1:0]        i_dma_data;
    logic [NCH-1:0]       i_ch_int;
    logic                 o_int;
    logic [NCH-1:0]       o_int_vec;

    sdio_multi #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .o_ch_wb_cyc(o_ch_wb_cyc), .o_ch_wb_stb(o_ch_wb_stb), .o_ch_wb_we(o_ch_wb_we),
        .o_ch_wb_addr(o_ch_wb_addr), .o_ch_wb_data(o_ch_wb_data), .o_ch_wb_sel(o_ch_wb_sel),
        .i_ch_wb_stall(i_ch_wb_stall), .i_ch_wb_ack(i_ch_wb_ack), .i_ch_wb_data(i_ch_wb_data),
        .i_ch_dma_cyc(i_ch_dma_cyc), .i_ch_dma_stb(i_ch_dma_stb), .i_ch_dma_we(i_ch_dma_we),
        .i_ch_dma_addr(i_ch_dma_addr), .i_ch_dma_data(i_ch_dma_data), .i_ch_dma_sel(i_ch_dma_sel),
        .o_ch_dma_stall(o_ch_dma_stall), .o_ch_dma_ack(o_ch_dma_ack), .o_ch_dma_err(o_ch_dma_err),
        .o_ch_dma_data(o_ch_dma_data),
        .o_dma_cyc(o_dma_cyc), .o_dma_stb(o_dma_stb), .o_dma_we(o_dma_we),
        .o_dma_addr(o_dma_addr), .o_dma_data(o_dma_data), .o_dma_sel(o_dma_sel),
        .i_dma_stall(i_dma_stall), .i_dma_ack(i_dma_ack), .i_dma_err(i_dma_err),
        .i_dma_data(i_dma_data),
        .i_ch_int(i_ch_int), .o_int(o_int), .o_int_vec(o_int_vec)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc0_cnt = 0;

    // Reference DMA arbiter state: owner (-1 = none), round-robin pointer, lock.
    int             m_owner;
    int             m_rr;
    bit             m_lock;
    logic [NCH-1:0] prev_int;

    always @(negedge clk) if (o_ch_wb_cyc[0]) cyc0_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = '0;
        i_wb_data = '0; i_wb_sel = '0;
        i_ch_wb_stall = '0; i_ch_wb_ack = '0; i_ch_wb_data = '0;
        i_ch_dma_cyc = '0; i_ch_dma_stb = '0; i_ch_dma_we = '0;
        i_ch_dma_addr = '0; i_ch_dma_data = '0; i_ch_dma_sel = '0;
        i_dma_stall = 0; i_dma_ack = 0; i_dma_err = 0; i_dma_data = '0;
        i_ch_int = '0;
    endtask

    task automatic do_reset();
        i_reset = 1;
        step();
        step();
        i_reset = 0;
    endtask

    // One control read; ch >= NCH exercises the out-of-range path.
    task automatic ctl_read(input int ch, input logic [2:0] rg, input int dly,
                            input logic [31:0] val);
        logic [NCH-1:0]   oh;
        logic [LGNCH-1:0] chb;
        chb = ch[LGNCH-1:0];
        oh  = '0;
        if (ch < NCH) oh[ch] = 1'b1;
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = {chb, rg};
        for (int k = 0; k < NCH; k++) i_ch_wb_data[k*MW +: MW] = $urandom | 32'h1;
        if (ch < NCH) i_ch_wb_data[ch*MW +: MW] = val;
        #1;
        chk("ctl_accept_stall", o_wb_stall, 0);
        step();
        i_wb_stb = 0;
        #1;
        if (ch >= NCH) begin
            chk("oor_ack", o_wb_ack, 1);
            chk("oor_data", o_wb_data, 0);
            chk("oor_cyc", o_ch_wb_cyc, 0);
        end else begin
            chk("ctl_cyc", o_ch_wb_cyc, oh);
            chk("ctl_stb", o_ch_wb_stb, oh);
            chk("ctl_reg", o_ch_wb_addr, rg);
            chk("ctl_busy", o_wb_stall, 1);
            for (int i = 0; i < dly; i++) begin
                step();
                chk("ctl_wait_ack", o_wb_ack, 0);
                chk("ctl_stb_done", o_ch_wb_stb, 0);
            end
            i_ch_wb_ack = oh;
            step();
            i_ch_wb_ack = '0;
            chk("ctl_ack", o_wb_ack, 1);
            chk("ctl_data", o_wb_data, val);
            chk("ctl_idle_cyc", o_ch_wb_cyc, 0);
        end
        i_wb_cyc = 0;
        step();
        chk("ctl_ack_pulse", o_wb_ack, 0);
    endtask

    task automatic dma_check();
        logic [NCH-1:0] e_stall, e_ack, e_err;
        logic           e_cyc, e_stb;
        e_stall = '1; e_ack = '0; e_err = '0; e_cyc = 0; e_stb = 0;
        if (m_owner >= 0) begin
            e_stall[m_owner] = i_dma_stall | m_lock;
            e_ack[m_owner]   = i_dma_ack;
            e_err[m_owner]   = i_dma_err;
            e_cyc = i_ch_dma_cyc[m_owner] & ~m_lock;
            e_stb = i_ch_dma_stb[m_owner] & ~m_lock;
            chk("dma_addr", o_dma_addr, i_ch_dma_addr[m_owner*AW +: AW]);
            chk("dma_wdata", o_dma_data, i_ch_dma_data[m_owner*DW +: DW]);
            chk("dma_sel", o_dma_sel, i_ch_dma_sel[m_owner*(DW/8) +: DW/8]);
            chk("dma_we", o_dma_we, i_ch_dma_we[m_owner]);
        end
        chk("dma_cyc", o_dma_cyc, e_cyc);
        chk("dma_stb", o_dma_stb, e_stb);
        chk("dma_stall_vec", o_ch_dma_stall, e_stall);
        chk("dma_ack_vec", o_ch_dma_ack, e_ack);
        chk("dma_err_vec", o_ch_dma_err, e_err);
        chk("dma_rdata", o_ch_dma_data, i_dma_data);
    endtask

    // Applies the arbitration rules to the inputs present at the coming edge.
    task automatic dma_model_update();
        if (m_owner >= 0) begin
            if (!i_ch_dma_cyc[m_owner]) begin
                m_owner = -1;
                m_lock  = 0;
            end else if (i_dma_err) begin
                m_lock = 1;
            end
        end
        if (m_owner < 0) begin
            for (int i = 1; i <= NCH; i++) begin
                int c;
                c = (m_rr + i) % NCH;
                if (i_ch_dma_cyc[c]) begin
                    m_owner = c;
                    m_rr    = c;
                    break;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int             order[$];
        int             gaps[$];
        int             beats[NCH];
        bit             drop[NCH];
        bit             ch_on[NCH];
        int             idle_run;
        bit             prev_cyc;
        int             owner_now;
        int             c0_before;

        zero_inputs();
        // Drive requests and interrupts during reset: reset must still win.
        i_ch_dma_cyc = '1;
        i_ch_int     = '1;
        do_reset();
        chk("rst_wb_ack", o_wb_ack, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_wb_stall", o_wb_stall, 0);
        chk("rst_ch_cyc", o_ch_wb_cyc, 0);
        chk("rst_ch_stb", o_ch_wb_stb, 0);
        chk("rst_dma_cyc", o_dma_cyc, 0);
        chk("rst_dma_stb", o_dma_stb, 0);
        chk("rst_dma_stall", o_ch_dma_stall, 3'b111);
        chk("rst_dma_ack", o_ch_dma_ack, 0);
        chk("rst_dma_err", o_ch_dma_err, 0);
        chk("rst_int", o_int, 0);
        chk("rst_int_vec", o_int_vec, 0);
        i_ch_dma_cyc = '0;
        i_ch_int     = '0;
        step();

        // Control read: channel 1, register 3, channel ack two cycles after stb.
        c0_before = cyc0_cnt;
        ctl_read(1, 3'd3, 2, 32'hDEADBEEF);
        chk("ctl_no_ch0", cyc0_cnt - c0_before, 0);

        // Out-of-range channel 3.
        ctl_read(3, 3'd0, 0, 32'h0);

        // Control write to channel 0: shared write fields reach the channel.
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = {2'd0, 3'd6};
        i_wb_data = 32'hA5C3_1234; i_wb_sel = 4'b1010;
        step();
        i_wb_stb = 0;
        #1;
        chk("wr_we", o_ch_wb_we, 1);
        chk("wr_data", o_ch_wb_data, 32'hA5C3_1234);
        chk("wr_sel", o_ch_wb_sel, 4'b1010);
        chk("wr_addr", o_ch_wb_addr, 6);
        i_ch_wb_ack = 3'b001;
        step();
        i_ch_wb_ack = '0;
        chk("wr_ack", o_wb_ack, 1);
        i_wb_cyc = 0; i_wb_we = 0;
        step();

        // Abort while the channel is stalling.
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_addr = {2'd2, 3'd1};
        i_ch_wb_stall = 3'b100;
        step();
        i_wb_stb = 0;
        #1;
        chk("abt_cyc", o_ch_wb_cyc, 3'b100);
        step();
        chk("abt_stb_held", o_ch_wb_stb, 3'b100);
        i_wb_cyc = 0;
        #1;
        chk("abt_drop_cyc", o_ch_wb_cyc, 0);
        chk("abt_drop_stb", o_ch_wb_stb, 0);
        step();
        i_ch_wb_ack = 3'b100;
        #1;
        chk("abt_idle", o_wb_stall, 0);
        step();
        chk("abt_no_ack", o_wb_ack, 0);
        i_ch_wb_ack = '0; i_ch_wb_stall = '0;
        step();

        // Round-robin: channels 0 and 1 each do 4-beat bursts, drop cyc for
        // one cycle and re-request.
        i_dma_ack = 1; i_dma_stall = 0;
        idle_run = 0; prev_cyc = 0;
        for (int k = 0; k < NCH; k++) begin beats[k] = 0; drop[k] = 0; end
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            for (int k = 0; k < 2; k++) begin
                i_ch_dma_cyc[k] = ~drop[k];
                i_ch_dma_stb[k] = ~drop[k];
                drop[k] = 0;
            end
            #1;
            owner_now = -1;
            for (int k = 0; k < NCH; k++) if (!o_ch_dma_stall[k]) owner_now = k;
            if (o_dma_cyc) begin
                chk("rr_owner_valid", owner_now >= 0, 1);
                if (owner_now >= 0) begin
                    if (!prev_cyc) begin
                        order.push_back(owner_now);
                        if (order.size() > 1) gaps.push_back(idle_run);
                    end
                    chk("iso_ack", o_ch_dma_ack, 64'(1) << owner_now);
                    beats[owner_now]++;
                    if (beats[owner_now] == 4) begin
                        beats[owner_now] = 0;
                        drop[owner_now]  = 1;
                    end
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_cyc = o_dma_cyc;
            step();
        end
        chk("rr_bursts", order.size(), 4);
        foreach (order[i]) chk("rr_order", order[i], i % 2);
        foreach (gaps[i]) chk("rr_gap", gaps[i], 1);
        i_ch_dma_cyc = '0; i_ch_dma_stb = '0; i_dma_ack = 0;
        step();
        step();

        // Bus error during channel 1's burst, channel 0 waiting.
        i_ch_dma_cyc = 3'b010; i_ch_dma_stb = 3'b010;
        step();
        chk("err_cyc_up", o_dma_cyc, 1);
        chk("err_owner1", o_ch_dma_stall, 3'b101);
        i_ch_dma_cyc = 3'b011; i_ch_dma_stb = 3'b011;
        i_dma_err = 1;
        #1;
        chk("err_route", o_ch_dma_err, 3'b010);
        step();
        i_dma_err = 0;
        #1;
        chk("err_cyc_low", o_dma_cyc, 0);
        chk("err_stall", o_ch_dma_stall, 3'b111);
        step();
        chk("err_locked", o_dma_cyc, 0);
        i_ch_dma_cyc = 3'b001; i_ch_dma_stb = 3'b001;
        #1;
        chk("err_release_idle", o_dma_cyc, 0);
        step();
        chk("err_next_cyc", o_dma_cyc, 1);
        chk("err_next_owner0", o_ch_dma_stall, 3'b110);
        i_ch_dma_cyc = '0; i_ch_dma_stb = '0;
        step();
        step();

        // Reset with a DMA grant held and the control path BUSY.
        i_ch_dma_cyc = 3'b111; i_ch_dma_stb = 3'b111;
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_addr = {2'd0, 3'd2};
        i_ch_wb_stall = 3'b001;
        step();
        i_wb_stb = 0;
        #1;
        chk("mid_busy", o_wb_stall, 1);
        chk("mid_granted", o_dma_cyc, 1);
        i_reset = 1;
        step();
        i_reset = 0;
        #1;
        chk("mid_rst_ch_cyc", o_ch_wb_cyc, 0);
        chk("mid_rst_ch_stb", o_ch_wb_stb, 0);
        chk("mid_rst_stall", o_wb_stall, 0);
        chk("mid_rst_ack", o_wb_ack, 0);
        chk("mid_rst_dma_cyc", o_dma_cyc, 0);
        chk("mid_rst_dma_stall", o_ch_dma_stall, 3'b111);
        step();
        chk("mid_next_owner0", o_ch_dma_stall, 3'b110);
        chk("mid_next_cyc", o_dma_cyc, 1);
        zero_inputs();
        step();

        // Randomized DMA and interrupt traffic against the model.
        do_reset();
        m_owner = -1; m_rr = NCH - 1; m_lock = 0; prev_int = '0;
        for (int k = 0; k < NCH; k++) ch_on[k] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if (ch_on[k]) begin
                    if ($urandom_range(0, 5) == 0) ch_on[k] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    ch_on[k] = 1;
                end
                i_ch_dma_cyc[k] = ch_on[k];
                i_ch_dma_stb[k] = ch_on[k] & ($urandom_range(0, 3) != 0);
                i_ch_dma_we[k]  = $urandom_range(0, 1) == 1;
                i_ch_dma_addr[k*AW +: AW]       = AW'({$urandom, $urandom});
                i_ch_dma_data[k*DW +: DW]       = {$urandom, $urandom};
                i_ch_dma_sel[k*(DW/8) +: DW/8]  = 8'($urandom);
            end
            i_dma_stall = $urandom_range(0, 2) == 0;
            i_dma_ack   = $urandom_range(0, 1) == 1;
            i_dma_err   = $urandom_range(0, 19) == 0;
            i_dma_data  = {$urandom, $urandom};
            i_ch_int    = NCH'($urandom);
            #1;
            dma_check();
            chk("int_vec", o_int_vec, prev_int);
            chk("int_or", o_int, |prev_int);
            dma_model_update();
            prev_int = i_ch_int;
            step();
        end
        zero_inputs();
        step();
        step();

        // Randomized control reads, including the missing channel 3.
        for (int t = 0; t < 10; t++) begin
            ctl_read($urandom_range(0, 3), 3'($urandom), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
